// File: rtl/dp_link_train.sv
// DisplayPort 2-lane link-training sequencer: clock recovery then channel EQ over DPCD AUX.
// Optional macro LT_RATE_FALLBACK_EN: on CR failure at 0x0A retrain once at 0x06, exposing rate_fb.
module dp_link_train #(
    parameter int unsigned CR_WAIT  = 16200,
    parameter int unsigned EQ_WAIT  = 64800,
    parameter int unsigned MAXTRIES = 5
) (
    input  logic        dpclk,
    input  logic        dpreset_n,
    input  logic        start,
    input  logic [7:0]  linkbw,
    output logic [2:0]  phymode,
    output logic [1:0]  drvswing,
    output logic [1:0]  drvpre,
    output logic        auxreq,
    output logic        auxwr,
    output logic [19:0] auxaddr,
    output logic [7:0]  auxwdata,
    input  logic        auxack,
    input  logic        auxerr,
    input  logic [7:0]  auxrdata,
`ifdef LT_RATE_FALLBACK_EN
    output logic        rate_fb,
`endif
    output logic        busy,
    output logic        linkup,
    output logic        fail
);
    localparam int unsigned MaxWait = (EQ_WAIT > CR_WAIT) ? EQ_WAIT : CR_WAIT;
    localparam int unsigned TimerW  = $clog2(MaxWait + 1);
    localparam int unsigned CntW    = $clog2(MAXTRIES + 1);

    typedef enum logic [3:0] {
        StIdle, StWBw, StWLc, StWP1, StWDrv, StCrWait, StRCr, StRAdj,
        StWP2, StEqWait, StREq, StRLane, StWP0, StLinkup, StFail
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          phymode_q, phymode_d;
    logic [1:0]          swing_q, swing_d, pre_q, pre_d;
    logic                auxreq_q, auxreq_d, auxwr_q, auxwr_d;
    logic [19:0]         auxaddr_q, auxaddr_d;
    logic [7:0]          auxwdata_q, auxwdata_d;
    logic                busy_q, busy_d, linkup_q, linkup_d, fail_q, fail_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [CntW-1:0]     cr_cnt_q, cr_cnt_d, eq_cnt_q, eq_cnt_d;
    logic                lane_q, lane_d, eq_phase_q, eq_phase_d;
    logic [7:0]          rate_q, rate_d;
`ifdef LT_RATE_FALLBACK_EN
    logic                rate_fb_q, rate_fb_d;
`endif

    logic                ack, is_aux, req_wr, cr_fail, eq_fail;
    logic [19:0]         req_addr;
    logic [7:0]          req_data, drv_byte;
    logic [1:0]          new_swing, new_pre;
    logic [CntW-1:0]     cr_next, eq_next;

    function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (&v) ? v : v + CntW'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        phymode_d  = phymode_q;
        swing_d    = swing_q;
        pre_d      = pre_q;
        auxreq_d   = auxreq_q;
        auxwr_d    = auxwr_q;
        auxaddr_d  = auxaddr_q;
        auxwdata_d = auxwdata_q;
        timer_d    = timer_q;
        cr_cnt_d   = cr_cnt_q;
        eq_cnt_d   = eq_cnt_q;
        lane_d     = lane_q;
        eq_phase_d = eq_phase_q;
        rate_d     = rate_q;
`ifdef LT_RATE_FALLBACK_EN
        rate_fb_d  = rate_fb_q;
`endif
        ack       = auxreq_q & auxack;
        cr_fail   = 1'b0;
        eq_fail   = 1'b0;
        drv_byte  = {3'b000, pre_q, swing_q == 2'd3, swing_q};
        new_swing = max2(auxrdata[1:0], auxrdata[5:4]);
        new_pre   = max2(auxrdata[3:2], auxrdata[7:6]);
        cr_next   = (new_swing == swing_q) ? sat_inc(cr_cnt_q) : '0;
        eq_next   = sat_inc(eq_cnt_q);

        is_aux   = 1'b1;
        req_wr   = 1'b1;
        req_addr = 20'h00102;
        req_data = 8'h00;
        case (state_q)
            StWBw:   begin req_addr = 20'h00100; req_data = rate_q; end
            StWLc:   begin req_addr = 20'h00101; req_data = 8'h82; end
            StWP1:   req_data = 8'h21;
            StWDrv:  begin req_addr = lane_q ? 20'h00104 : 20'h00103; req_data = drv_byte; end
            StRCr,
            StREq:   begin req_wr = 1'b0; req_addr = 20'h00202; end
            StRAdj:  begin req_wr = 1'b0; req_addr = 20'h00206; end
            StRLane: begin req_wr = 1'b0; req_addr = 20'h00204; end
            StWP2:   req_data = 8'h22;
            StWP0:   req_data = 8'h00;
            default: is_aux = 1'b0;
        endcase

        // Request fields are captured only on the raising edge so they hold steady until ack.
        if (is_aux && !auxreq_q) begin
            auxreq_d   = 1'b1;
            auxwr_d    = req_wr;
            auxaddr_d  = req_addr;
            auxwdata_d = req_data;
        end

        case (state_q)
            StIdle, StLinkup, StFail: begin
                if (start) begin
                    state_d    = StWBw;
                    rate_d     = linkbw;
                    phymode_d  = 3'd0;
                    swing_d    = 2'd0;
                    pre_d      = 2'd0;
                    cr_cnt_d   = '0;
                    eq_cnt_d   = '0;
                    lane_d     = 1'b0;
                    eq_phase_d = 1'b0;
`ifdef LT_RATE_FALLBACK_EN
                    rate_fb_d  = 1'b0;
`endif
                end
            end
            StCrWait: begin
                if (timer_q == '0) state_d = StRCr;
                else               timer_d = timer_q - TimerW'(1);
            end
            StEqWait: begin
                if (timer_q == '0) state_d = StREq;
                else               timer_d = timer_q - TimerW'(1);
            end
            default: begin
                if (ack) begin
                    auxreq_d = 1'b0;
                    if (auxerr) begin
                        state_d = StFail;
                    end else begin
                        case (state_q)
                            StWBw: state_d = StWLc;
                            StWLc: state_d = StWP1;
                            StWP1: begin
                                phymode_d  = 3'd2;
                                swing_d    = 2'd0;
                                pre_d      = 2'd0;
                                cr_cnt_d   = '0;
                                lane_d     = 1'b0;
                                eq_phase_d = 1'b0;
                                state_d    = StWDrv;
                            end
                            StWDrv: begin
                                lane_d = ~lane_q;
                                if (lane_q) begin
                                    state_d = eq_phase_q ? StEqWait : StCrWait;
                                    timer_d = eq_phase_q ? TimerW'(EQ_WAIT - 1)
                                                         : TimerW'(CR_WAIT - 1);
                                end
                            end
                            StRCr: state_d = (auxrdata[0] && auxrdata[4]) ? StWP2 : StRAdj;
                            StRAdj: begin
                                swing_d = new_swing;
                                pre_d   = new_pre;
                                state_d = StWDrv;
                                if (!eq_phase_q) begin
                                    cr_cnt_d = cr_next;
                                    // Max swing already applied and CR still not locked: give up.
                                    if (cr_next == CntW'(MAXTRIES) || swing_q == 2'd3) cr_fail = 1'b1;
                                end
                            end
                            StWP2: begin
                                phymode_d  = 3'd3;
                                eq_phase_d = 1'b1;
                                state_d    = StEqWait;
                                timer_d    = TimerW'(EQ_WAIT - 1);
                            end
                            StREq: begin
                                if (!(auxrdata[0] && auxrdata[4])) begin
                                    eq_phase_d = 1'b0;
                                    state_d    = StWP1;
                                end else if ((auxrdata & 8'h77) == 8'h77) begin
                                    state_d = StRLane;
                                end else begin
                                    eq_fail = 1'b1;
                                end
                            end
                            StRLane: begin
                                if (auxrdata[0]) state_d = StWP0;
                                else             eq_fail = 1'b1;
                            end
                            StWP0: begin
                                phymode_d = 3'd1;
                                state_d   = StLinkup;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        if (cr_fail) begin
`ifdef LT_RATE_FALLBACK_EN
            if (rate_q == 8'h0A) begin
                rate_d     = 8'h06;
                rate_fb_d  = 1'b1;
                swing_d    = 2'd0;
                pre_d      = 2'd0;
                cr_cnt_d   = '0;
                eq_cnt_d   = '0;
                lane_d     = 1'b0;
                eq_phase_d = 1'b0;
                phymode_d  = 3'd0;
                state_d    = StWBw;
            end else begin
                state_d = StFail;
            end
`else
            state_d = StFail;
`endif
        end

        if (eq_fail) begin
            eq_cnt_d = eq_next;
            state_d  = (eq_next == CntW'(MAXTRIES)) ? StFail : StRAdj;
        end

        if (state_d == StFail) phymode_d = 3'd0;
        busy_d   = !(state_d == StIdle || state_d == StLinkup || state_d == StFail);
        linkup_d = (state_d == StLinkup);
        fail_d   = (state_d == StFail);
    end

    always_ff @(posedge dpclk or negedge dpreset_n) begin
        if (!dpreset_n) begin
            state_q    <= StIdle;
            phymode_q  <= 3'd0;
            swing_q    <= 2'd0;
            pre_q      <= 2'd0;
            auxreq_q   <= 1'b0;
            auxwr_q    <= 1'b0;
            auxaddr_q  <= 20'h0;
            auxwdata_q <= 8'h00;
            busy_q     <= 1'b0;
            linkup_q   <= 1'b0;
            fail_q     <= 1'b0;
            timer_q    <= '0;
            cr_cnt_q   <= '0;
            eq_cnt_q   <= '0;
            lane_q     <= 1'b0;
            eq_phase_q <= 1'b0;
            rate_q     <= 8'h00;
`ifdef LT_RATE_FALLBACK_EN
            rate_fb_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phymode_q  <= phymode_d;
            swing_q    <= swing_d;
            pre_q      <= pre_d;
            auxreq_q   <= auxreq_d;
            auxwr_q    <= auxwr_d;
            auxaddr_q  <= auxaddr_d;
            auxwdata_q <= auxwdata_d;
            busy_q     <= busy_d;
            linkup_q   <= linkup_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            cr_cnt_q   <= cr_cnt_d;
            eq_cnt_q   <= eq_cnt_d;
            lane_q     <= lane_d;
            eq_phase_q <= eq_phase_d;
            rate_q     <= rate_d;
`ifdef LT_RATE_FALLBACK_EN
            rate_fb_q  <= rate_fb_d;
`endif
        end
    end

    assign phymode  = phymode_q;
    assign drvswing = swing_q;
    assign drvpre   = pre_q;
    assign auxreq   = auxreq_q;
    assign auxwr    = auxwr_q;
    assign auxaddr  = auxaddr_q;
    assign auxwdata = auxwdata_q;
    assign busy     = busy_q;
    assign linkup   = linkup_q;
    assign fail     = fail_q;
`ifdef LT_RATE_FALLBACK_EN
    assign rate_fb  = rate_fb_q;
`endif

endmodule
